// File: rtl/dcache_controller_pkg.sv
// Shared encodings and geometry for the direct-mapped write-back data cache.
package dcache_controller_pkg;

    localparam int LINE_W = 256;
    localparam int WORD_W = 32;
    localparam int OFF_W  = 5;
    localparam int WSEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side load/store port and line-wide memory port of the data cache.
interface dcache_controller_if;

    logic                                     cpu_req_i;
    logic                                     cpu_we_i;
    logic [31:0]                              cpu_addr_i;
    logic [31:0]                              cpu_wdata_i;
    logic [31:0]                              cpu_rdata_o;
    logic                                     cpu_stall_o;
    logic                                     mem_req_o;
    logic                                     mem_we_o;
    logic [31:0]                              mem_addr_o;
    logic [dcache_controller_pkg::LINE_W-1:0] mem_wdata_o;
    logic [dcache_controller_pkg::LINE_W-1:0] mem_rdata_i;
    logic                                     mem_ack_i;

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dcache_controller_sram.sv
// Tag/valid/dirty and line storage: async read by index, sync line fill or single-word store.
module dcache_controller_sram
    import dcache_controller_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 32 - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [LINE_W-1:0] rd_line,
    input  logic              line_we,
    input  logic [IDX_W-1:0]  line_idx,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic [LINE_W-1:0] line_data,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0] word_data
);

    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic [LINE_W-1:0]    data [NUM_LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (line_we) begin
            valid[line_idx] <= 1'b1;
            dirty[line_idx] <= 1'b0;
        end else if (word_we) begin
            dirty[word_idx] <= 1'b1;
        end
    end

    // NOTE: the arrays sit outside the reset; valid=0 already hides their contents,
    // and leaving them unreset lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[line_idx] <= line_tag;
            data[line_idx] <= line_data;
        end else if (word_we) begin
            data[word_idx][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

    assign rd_tag   = tags[rd_idx];
    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_line  = data[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache: hit compare, stall and miss FSM.
module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int NUM_LINES = 16
) (
    input  logic               clk_i,
    input  logic               start_i,
    dcache_controller_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - IDX_W - OFF_W;

    state_e             state;
    logic               mem_req;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;

    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               rd_dirty;
    logic [LINE_W-1:0]  rd_line;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [WSEL_W-1:0]  wsel;
    logic               hit;
    logic               hit_idle;
    logic               unused_ok;

    assign idx       = bus.cpu_addr_i[OFF_W +: IDX_W];
    assign tag       = bus.cpu_addr_i[31 -: TAG_W];
    assign wsel      = bus.cpu_addr_i[OFF_W-1:2];
    assign unused_ok = ^bus.cpu_addr_i[1:0];

    assign hit      = rd_valid && (rd_tag == tag);
    assign hit_idle = (state == IDLE) && hit;

    assign bus.cpu_stall_o = bus.cpu_req_i && !hit_idle;
    assign bus.cpu_rdata_o = (bus.cpu_req_i && !bus.cpu_we_i && hit_idle)
                           ? rd_line[wsel*WORD_W +: WORD_W] : '0;

    dcache_controller_sram #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_sram (
        .clk      (clk_i),
        .rst_n    (start_i),
        .rd_idx   (idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_line  (rd_line),
        .line_we  ((state == FILL) && bus.mem_ack_i),
        .line_idx (req_idx),
        .line_tag (req_tag),
        .line_data(bus.mem_rdata_i),
        .word_we  (bus.cpu_req_i && bus.cpu_we_i && hit_idle),
        .word_idx (idx),
        .word_sel (wsel),
        .word_data(bus.cpu_wdata_i)
    );

    // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_tag   <= '0;
            req_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req_i && !hit) begin
                        // Latch the miss address so a dropped request still installs the right line.
                        req_tag <= tag;
                        req_idx <= idx;
                        mem_req <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {rd_tag, idx, {OFF_W{1'b0}}};
                            mem_wdata <= rd_line;
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag, idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ack_i) begin
                        state     <= FILL;
                        mem_we    <= 1'b0;
                        mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        mem_wdata <= '0;
                    end
                end
                FILL: begin
                    if (bus.mem_ack_i) begin
                        state    <= DONE;
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;

endmodule
